// File: rtl/dcache_fill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dcache_fill_ctrl_pkg
//
// Shared constants and types for the direct-mapped, write-through,
// write-allocate data cache and its line-fill controller.
//
// Byte address layout (ADDR_W = 16, 64 sets, 8 x 16-bit words per line):
//   [15:10] tag   [9:4] index   [3:1] word offset   [0] ignored
// -----------------------------------------------------------------------------
package dcache_fill_ctrl_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int NUM_SETS        = 64;
    localparam int WORDS_PER_BLOCK = 8;

    localparam int OFFSET_W   = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int OFFSET_LSB = 1;                      // byte bit 0 is ignored
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;
    localparam int TAG_W      = ADDR_W - TAG_LSB;

    // One bit wider than the offset so that "all words done" is representable.
    localparam int CNT_W = OFFSET_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        addr_fields_t f;
        f.tag    = addr[TAG_LSB    +: TAG_W];
        f.index  = addr[INDEX_LSB  +: INDEX_W];
        f.offset = addr[OFFSET_LSB +: OFFSET_W];
        return f;
    endfunction

    // Byte address of word 0 of the line identified by tag/index.
    function automatic logic [ADDR_W-1:0] line_base(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] index);
        return {tag, index, {INDEX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_meta_store.sv
// -----------------------------------------------------------------------------
// dcache_meta_store
//
// Valid bits and tag array of the data cache, plus the hit comparator.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset; clears every valid bit
//   index      in   lookup set index (from the CPU address)
//   tag        in   lookup tag (from the CPU address)
//   fill_index in   set being completed by a line fill
//   tag_wr     in   tag value written into fill_index
//   set_valid  in   write tag_wr and mark fill_index valid at the clock edge
//   hit        out  valid[index] & (tag_store[index] == tag), combinational
// -----------------------------------------------------------------------------
module dcache_meta_store
    import dcache_fill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   tag_wr,
    input  logic               set_valid,
    output logic               hit
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;
    logic [TAG_W-1:0]    tag_mem [NUM_SETS];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        valid_d = valid_q;
        if (set_valid) begin
            valid_d[fill_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: storage arrays are deliberately not reset; the valid bits gate
    // every use of a tag, so stale contents are harmless and a reset network
    // across the whole array would only cost area and timing.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_mem[fill_index] <= tag_wr;
        end
    end

    assign hit = valid_q[index] & (tag_mem[index] == tag);

endmodule

// File: rtl/dcache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_fill_ctrl
//
// Direct-mapped, write-through, write-allocate data cache sitting between the
// CPU MEM stage and a pipelined multicycle main memory.
//
// A hit read returns data combinationally in the same cycle. A hit write
// updates the line and forwards the store to memory in the same cycle. A miss
// stalls the CPU, fetches the whole line as 8 back-to-back word reads, then
// returns to IDLE where the still-held request hits and completes.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   data_addr    in   CPU byte address (bit 0 ignored for lookup)
//   data_in      in   CPU store data
//   mem_read     in   CPU load request
//   mem_write    in   CPU store request (wins when both are high)
//   d_output     out  load data, 0 unless a hit read is in progress
//   mem_stall    out  CPU must hold its request and freeze the pipeline
//   mm_addr      out  main-memory byte address
//   mm_data_out  out  main-memory write data
//   mm_en        out  main-memory request strobe
//   mm_wr        out  main-memory write (1) / read (0)
//   mm_data_in   in   main-memory read data
//   mm_valid     in   mm_data_in valid; responses return in issue order
// -----------------------------------------------------------------------------
module dcache_fill_ctrl
    import dcache_fill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] d_output,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_data_out,
    output logic              mm_en,
    output logic              mm_wr,
    input  logic [DATA_W-1:0] mm_data_in,
    input  logic              mm_valid
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    addr_fields_t req_f;
    logic         req;
    logic         hit;

    assign req_f = split_addr(data_addr);
    assign req   = mem_read | mem_write;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   issue_cnt_q,  issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q,   recv_cnt_d;
    logic [TAG_W-1:0]   fill_tag_q,   fill_tag_d;
    logic [INDEX_W-1:0] fill_index_q, fill_index_d;

    // Single write port into the data array, shared by store hits and fills
    // (the two never occur in the same cycle).
    logic                arr_we;
    logic [INDEX_W-1:0]  arr_index;
    logic [OFFSET_W-1:0] arr_offset;
    logic [DATA_W-1:0]   arr_wdata;
    logic                set_valid;

    logic [DATA_W-1:0] data_mem [NUM_SETS][WORDS_PER_BLOCK];
    logic [DATA_W-1:0] line_word;

    assign line_word = data_mem[req_f.index][req_f.offset];

    // ------------------------------------------------------------------
    // Valid/tag storage
    // ------------------------------------------------------------------
    dcache_meta_store u_meta (
        .clk        (clk),
        .rst        (rst),
        .index      (req_f.index),
        .tag        (req_f.tag),
        .fill_index (fill_index_q),
        .tag_wr     (fill_tag_q),
        .set_valid  (set_valid),
        .hit        (hit)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        fill_tag_d   = fill_tag_q;
        fill_index_d = fill_index_q;

        arr_we      = 1'b0;
        arr_index   = req_f.index;
        arr_offset  = req_f.offset;
        arr_wdata   = data_in;
        set_valid   = 1'b0;

        d_output    = '0;
        mem_stall   = 1'b0;
        mm_en       = 1'b0;
        mm_wr       = 1'b0;
        mm_addr     = '0;
        mm_data_out = '0;

        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    if (mem_write) begin
                        // Write-through: update the line and forward the
                        // store to memory in the same cycle.
                        arr_we      = 1'b1;
                        mm_en       = 1'b1;
                        mm_wr       = 1'b1;
                        mm_addr     = data_addr;
                        mm_data_out = data_in;
                    end else begin
                        d_output = line_word;
                    end
                end else if (req) begin
                    // Miss: stall immediately, nothing is sent to memory this
                    // cycle; a store is replayed as a hit once the line is in.
                    mem_stall    = 1'b1;
                    state_d      = FILL;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                    fill_tag_d   = req_f.tag;
                    fill_index_d = req_f.index;
                end
            end

            FILL: begin
                mem_stall = 1'b1;

                if (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK)) begin
                    mm_en       = 1'b1;
                    mm_addr     = line_base(fill_tag_q, fill_index_q)
                                + (ADDR_W'(issue_cnt_q) << 1);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end

                if (mm_valid) begin
                    arr_we     = 1'b1;
                    arr_index  = fill_index_q;
                    arr_offset = recv_cnt_q[OFFSET_W-1:0];
                    arr_wdata  = mm_data_in;
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);

                    // Last word: the line becomes valid at this edge, so the
                    // held request hits in the following IDLE cycle.
                    if (recv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        set_valid = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            fill_tag_q   <= fill_tag_d;
            fill_index_q <= fill_index_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_mem[arr_index][arr_offset] <= arr_wdata;
        end
    end

endmodule
